// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS datapath: default width,
// divider state encodings and two's-complement helpers.
package cpu_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_CALC   = 2'b01,
        DIV_FINISH = 2'b10
    } div_state_t;

    // Two's-complement negate when neg is set; wraps modulo 2^CPU_WIDTH.
    function automatic logic [CPU_WIDTH-1:0] cond_neg(
        input logic [CPU_WIDTH-1:0] value,
        input logic                 neg
    );
        return neg ? ((~value) + CPU_WIDTH'(1)) : value;
    endfunction

    // Magnitude of a signed word; the most negative value maps to itself,
    // which is still the correct unsigned magnitude.
    function automatic logic [CPU_WIDTH-1:0] abs_val(
        input logic [CPU_WIDTH-1:0] value
    );
        return cond_neg(value, value[CPU_WIDTH-1]);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor magnitude if the partial remainder allows it.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH:0]   new_rem,
    output logic             q_bit
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_shift = {rem[WIDTH-1:0], q_msb};
        diff      = rem_shift - {1'b0, divisor_mag};
        // Sign bit of the extra remainder bit tells whether the subtract borrowed.
        q_bit     = ~diff[WIDTH];
        new_rem   = q_bit ? diff : rem_shift;
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider producing MIPS LO (quotient) and HI (remainder),
// one quotient bit per clock with a final sign-correction cycle.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    div_start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0]        hi_out,
    output logic [WIDTH-1:0]        lo_out,
    output logic                    div_done,
    output logic                    divzero,
    output logic                    busy
);

    div_state_t       state, state_next;
    logic [WIDTH:0]   rem, rem_next;
    logic [WIDTH-1:0] q, q_next;
    logic [WIDTH-1:0] dmag, dmag_next;
    logic             sign_q, sign_q_next;
    logic             sign_r, sign_r_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             done_next, divzero_next, busy_next;

    logic [WIDTH:0]   step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem),
        .q_msb       (q[WIDTH-1]),
        .divisor_mag (dmag),
        .new_rem     (step_rem),
        .q_bit       (step_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= DIV_IDLE;
            rem      <= '0;
            q        <= '0;
            dmag     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            counter  <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_done <= 1'b0;
            divzero  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            rem      <= rem_next;
            q        <= q_next;
            dmag     <= dmag_next;
            sign_q   <= sign_q_next;
            sign_r   <= sign_r_next;
            counter  <= counter_next;
            hi_out   <= hi_next;
            lo_out   <= lo_next;
            div_done <= done_next;
            divzero  <= divzero_next;
            busy     <= busy_next;
        end
    end

    always_comb begin
        state_next   = state;
        rem_next     = rem;
        q_next       = q;
        dmag_next    = dmag;
        sign_q_next  = sign_q;
        sign_r_next  = sign_r;
        counter_next = counter;
        hi_next      = hi_out;
        lo_next      = lo_out;
        done_next    = 1'b0;
        divzero_next = 1'b0;
        busy_next    = busy;

        case (state)
            DIV_IDLE: begin
                if (div_start) begin
                    // A zero divisor is reported and the results are left untouched.
                    if (divisor == '0) begin
                        divzero_next = 1'b1;
                    end else begin
                        sign_q_next  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_next  = dividend[WIDTH-1];
                        q_next       = abs_val(dividend);
                        dmag_next    = abs_val(divisor);
                        rem_next     = '0;
                        counter_next = CNT_W'(WIDTH - 1);
                        state_next   = DIV_CALC;
                        busy_next    = 1'b1;
                    end
                end
            end

            DIV_CALC: begin
                rem_next = step_rem;
                q_next   = {q[WIDTH-2:0], step_bit};
                if (counter == '0) begin
                    state_next = DIV_FINISH;
                end else begin
                    counter_next = counter - CNT_W'(1);
                end
            end

            DIV_FINISH: begin
                // Quotient truncates toward zero; remainder follows the dividend sign.
                lo_next    = cond_neg(q, sign_q);
                hi_next    = cond_neg(rem[WIDTH-1:0], sign_r);
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = DIV_IDLE;
            end

            default: begin
                state_next = DIV_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: latency/arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_div_unit;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               div_start = 1'b0;
    logic signed [31:0] dividend = '0;
    logic signed [31:0] divisor = '0;
    logic [31:0]        hi_out;
    logic [31:0]        lo_out;
    logic               div_done;
    logic               divzero;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;

    // Reference model state
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dz = 1'b0, m_busy = 1'b0;
    int          m_cnt = 0;
    longint      a_l, b_l, q_l, r_l;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .div_done  (div_done),
        .divzero   (divzero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Result appears 33 edges after an accepted start; starts are ignored meanwhile.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0; m_busy = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_lo = p_lo;
                    m_hi = p_hi;
                    m_done = 1'b1;
                end
            end else if (div_start) begin
                if (divisor == 0) begin
                    m_dz = 1'b1;
                end else begin
                    a_l = longint'(dividend);
                    b_l = longint'(divisor);
                    q_l = a_l / b_l;
                    r_l = a_l % b_l;
                    p_lo = q_l[31:0];
                    p_hi = r_l[31:0];
                    m_cnt = 33;
                end
            end
            m_busy = (m_cnt > 0);
        end
    end

    always @(negedge clk) begin
        check("hi_out", hi_out, m_hi);
        check("lo_out", lo_out, m_lo);
        check("div_done", {31'b0, div_done}, {31'b0, m_done});
        check("divzero", {31'b0, divzero}, {31'b0, m_dz});
        check("busy", {31'b0, busy}, {31'b0, m_busy});
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        e0        = cyc;
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_done) begin
                got = 1'b1;
                break;
            end
        end
        if (got) check({name, "_latency"}, cyc - e0, 33);
        else     check({name, "_done_seen"}, 32'd0, 32'd1);
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        start_op(a, b);
        wait_done(name);
        check({name, "_lo"}, lo_out, exp_lo);
        check({name, "_hi"}, hi_out, exp_hi);
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, div_done}, 32'd0);
        check("rst_dz", {31'b0, divzero}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        run_div("p7_2",   32'd7,          32'd2,          32'd3,          32'd1);
        run_div("n7_2",   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF);
        run_div("p7_n2",  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1);
        run_div("n7_n2",  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF);
        run_div("p100_5", 32'd100,        32'd5,          32'd20,         32'd0);

        // Divide by zero: single flag pulse, results kept
        start_op(32'd100, 32'd0);
        @(negedge clk);
        check("dz_pulse", {31'b0, divzero}, 32'd1);
        check("dz_nodone", {31'b0, div_done}, 32'd0);
        @(negedge clk);
        check("dz_clear", {31'b0, divzero}, 32'd0);
        check("dz_busy", {31'b0, busy}, 32'd0);
        repeat (35) @(negedge clk);
        check("dz_lo", lo_out, 32'd20);
        check("dz_hi", hi_out, 32'd0);

        run_div("min_n1", 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0);
        run_div("z_9",    32'd0,          32'd9,          32'd0,          32'd0);
        run_div("p5_9",   32'd5,          32'd9,          32'd0,          32'd5);

        // Second start at E5 must be ignored
        start_op(32'd7, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        dividend  = 32'd1000;
        divisor   = 32'd7;
        div_start = 1'b1;
        @(posedge clk);
        #1 div_start = 1'b0;
        wait_done("restart");
        check("restart_lo", lo_out, 32'd3);
        check("restart_hi", hi_out, 32'd1);

        // Asynchronous reset at E10 of 50/3
        start_op(32'd50, 32'd3);
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("arst_hi", hi_out, 32'd0);
        check("arst_lo", lo_out, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) @(negedge clk);
        check("arst_nodone_lo", lo_out, 32'd0);
        run_div("p50_3", 32'd50, 32'd3, 32'd16, 32'd2);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
